dcache_line_ctrl: RTL
=====================

// Module: dcache_line_ctrl
// PURPOSE
// - Sequences one way of the D-cache data store: 8 word banks (one per word offset), 128 sets, 32 B lines, each bank a 1-cycle-read BRAM with byte write enables.
// - Shares the banks between three users: CPU hit access (load/store, one word), line writeback (read 8 words, stream to AXI W) and line refill (write 8 AXI R beats).
// - Sits between the D-cache miss FSM / AXI bridge and the bank RAMs.
// PARAMETERS
// - IDX_W   7   set index width; RAM address = addr[IDX_W+4:5]
// - WORDS   8   words per line (banks); offset = addr[4:2]
// PORTS
// clk        in   1      clock, all state on rising edge
// rst        in   1      reset, asynchronous, active-low
// cpu_req    in   1      CPU access request (hit path)
// cpu_wen    in   4      byte enables; 0 = load
// cpu_addr   in   32     CPU byte address
// cpu_wdata  in   32     store data
// cpu_ready  out  1      request accepted this cycle
// cpu_rvalid out  1      load data valid (1 cycle after accept)
// cpu_rdata  out  32     load data
// wb_start   in   1      pulse: begin writeback of set wb_index
// wb_index   in   IDX_W  victim set
// wb_data    out  32     writeback beat
// wb_valid   out  1      beat valid
// wb_last    out  1      8th beat
// wb_ready   in   1      AXI W ready
// wb_done    out  1      pulse: last beat handshaken
// rf_start   in   1      pulse: begin refill of set rf_index
// rf_index   in   IDX_W  refill set
// rf_data    in   32     AXI R beat
// rf_valid   in   1      beat valid
// rf_ready   out  1      beat accepted
// rf_done    out  1      pulse: 8th beat written
// busy       out  1      state != IDLE or request pending
// ram_en     out  WORDS  per-bank enable
// ram_wen    out  4*WORDS per-bank byte enables (bank b = bits 4b+3:4b)
// ram_addr   out  IDX_W  shared set address
// ram_wdata  out  32     shared write data
// ram_rdata  in   32*WORDS bank read data (bank b = bits 32b+31:32b)
// BEHAVIOUR
// - Reset (rst=0, async): state IDLE, wb_pend/rf_pend=0, beat counter=0, line buffer=0; all outputs 0.
// - States: IDLE, WB_RD, WB_CAP, WB_SEND, RF_FILL. RAM ports are combinational from state/inputs.
// - wb_start/rf_start pulses set wb_pend/rf_pend, latching their index; pulses arriving while busy are held, not lost.
//   Pend clears on the state's entry. A start pulse for an already-pending type re-latches its index.
// - IDLE priority: (wb_start|wb_pend) -> WB_RD; else (rf_start|rf_pend) -> RF_FILL; else serve CPU.
//   Writeback beats refill so the victim is read before it is overwritten.
// - cpu_ready = IDLE & no start/pend. When cpu_req&cpu_ready: ram_en[off]=1, ram_wen[off]=cpu_wen, ram_addr=cpu_addr[11:5], ram_wdata=cpu_wdata.
//   For a load (cpu_wen==0), register off; next cycle cpu_rvalid=1 and cpu_rdata=ram_rdata[off]. Otherwise cpu_rdata=0. No CPU access outside IDLE.
// - WB_RD: ram_en=all 1s, wen=0, addr=wb_index -> WB_CAP.
// - WB_CAP: capture 256-bit ram_rdata into line buffer; cnt=0 -> WB_SEND.
// - WB_SEND: wb_valid=1, wb_data=buffer[cnt], wb_last=(cnt==7); cnt++ on wb_valid&wb_ready.
//   On the handshake with cnt==7: wb_done=1, -> IDLE. wb_data stable while wb_ready=0.
// - RF_FILL: rf_ready=1; on rf_valid: ram_en[cnt]=1, ram_wen[cnt]=4'hF, addr=rf_index, wdata=rf_data, cnt++.
//   On the 8th beat (cnt==7): rf_done=1, -> IDLE. Gaps in rf_valid stall without effect.
// - Counter is 3-bit and wraps to 0 at line end. wb_done/rf_done are single-cycle pulses.
// - Minimum latency: writeback 2 + 8 cycles; refill 8 cycles; back-to-back WB then RF has zero idle cycles if rf_pend is set.
// - Reset mid-operation aborts the sequence: no done pulse, pends lost, RAM contents untouched beyond beats already written.
// TESTING
// - Load: write bank3 set 5 = 32'hDEADBEEF; cpu_req, wen=0, addr=32'h000000AC -> ready, next cycle rvalid, rdata=32'hDEADBEEF.
// - Store: wen=4'b0011, wdata=32'h0000ABCD to addr 32'hAC -> ram_wen[15:12]=4'b0011 only; readback 32'hDEADABCD.
// - Writeback: set 9 words 0..7 = 32'h100+i; wb_start, wb_ready toggling 1/0 -> 8 beats 32'h100..32'h107 in order, wb_last on beat 8, wb_done once.
// - Refill: rf_start idx 9, 8 beats 32'hA0+i with two idle gaps -> banks hold A0..A7, rf_done once, no extra writes.
// - Simultaneous wb_start & rf_start & cpu_req in IDLE -> WB first, then RF with no IDLE gap, cpu_ready stays 0 until RF done.
// - Assert rst mid WB_SEND (beat 4) -> all outputs 0 same cycle; after release, IDLE with busy=0 and no done pulse.

Source files
------------

// File: rtl/dcache_line_ctrl.sv
// Data-store sequencer for one D-cache way: arbitrates the 8 word banks between
// CPU hit accesses, victim-line writeback to AXI W and line refill from AXI R.
module dcache_line_ctrl #(
    parameter int IDX_W = 7,
    parameter int WORDS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cpu_req,
    input  logic [3:0]           cpu_wen,
    input  logic [31:0]          cpu_addr,
    input  logic [31:0]          cpu_wdata,
    output logic                 cpu_ready,
    output logic                 cpu_rvalid,
    output logic [31:0]          cpu_rdata,
    input  logic                 wb_start,
    input  logic [IDX_W-1:0]     wb_index,
    output logic [31:0]          wb_data,
    output logic                 wb_valid,
    output logic                 wb_last,
    input  logic                 wb_ready,
    output logic                 wb_done,
    input  logic                 rf_start,
    input  logic [IDX_W-1:0]     rf_index,
    input  logic [31:0]          rf_data,
    input  logic                 rf_valid,
    output logic                 rf_ready,
    output logic                 rf_done,
    output logic                 busy,
    output logic [WORDS-1:0]     ram_en,
    output logic [4*WORDS-1:0]   ram_wen,
    output logic [IDX_W-1:0]     ram_addr,
    output logic [31:0]          ram_wdata,
    input  logic [32*WORDS-1:0]  ram_rdata
);

    localparam int OFF_W = $clog2(WORDS);
    localparam logic [OFF_W-1:0] LAST = OFF_W'(WORDS - 1);

    typedef enum logic [2:0] {IDLE, WB_RD, WB_CAP, WB_SEND, RF_FILL} state_t;

    state_t           state, state_nx;
    logic             wb_pend, rf_pend, ld_pend;
    logic [IDX_W-1:0] wb_idx_q, rf_idx_q, cur_idx;
    logic [OFF_W-1:0] cnt, ld_off, cpu_off;
    logic [31:0]      lbuf [WORDS];
    logic             wb_go, rf_go, cpu_acc, enter_wb, enter_rf;
    logic             unused_addr;

    assign unused_addr = ^{cpu_addr[31:IDX_W+5], cpu_addr[1:0]};
    assign cpu_off     = cpu_addr[OFF_W+1:2];
    assign wb_go       = wb_start | wb_pend;
    assign rf_go       = rf_start | rf_pend;
    // Gated by rst so every output reads 0 while reset is held.
    assign cpu_ready   = rst && (state == IDLE) && !wb_go && !rf_go;
    assign cpu_acc     = cpu_req && cpu_ready;
    assign busy        = (state != IDLE) || wb_pend || rf_pend;
    assign cpu_rvalid  = ld_pend;
    assign cpu_rdata   = ld_pend ? ram_rdata[32*ld_off +: 32] : '0;
    assign enter_wb    = (state == IDLE) && wb_go;
    // Refill may follow the last writeback beat directly, skipping IDLE.
    assign enter_rf    = ((state == IDLE) && !wb_go && rf_go) || (wb_done && rf_go);

    always_comb begin
        state_nx  = state;
        ram_en    = '0;
        ram_wen   = '0;
        ram_addr  = '0;
        ram_wdata = '0;
        wb_valid  = 1'b0;
        wb_last   = 1'b0;
        wb_data   = '0;
        wb_done   = 1'b0;
        rf_ready  = 1'b0;
        rf_done   = 1'b0;
        case (state)
            IDLE: begin
                if (wb_go)
                    state_nx = WB_RD;
                else if (rf_go)
                    state_nx = RF_FILL;
                else if (cpu_acc) begin
                    ram_en[cpu_off]          = 1'b1;
                    ram_wen[4*cpu_off +: 4]  = cpu_wen;
                    ram_addr                 = cpu_addr[IDX_W+4:5];
                    ram_wdata                = cpu_wdata;
                end
            end
            WB_RD: begin
                ram_en   = '1;
                ram_addr = cur_idx;
                state_nx = WB_CAP;
            end
            WB_CAP: state_nx = WB_SEND;
            WB_SEND: begin
                wb_valid = 1'b1;
                wb_data  = lbuf[cnt];
                wb_last  = (cnt == LAST);
                if (wb_ready && cnt == LAST) begin
                    wb_done  = 1'b1;
                    state_nx = rf_go ? RF_FILL : IDLE;
                end
            end
            RF_FILL: begin
                rf_ready = 1'b1;
                if (rf_valid) begin
                    ram_en[cnt]          = 1'b1;
                    ram_wen[4*cnt +: 4]  = '1;
                    ram_addr             = cur_idx;
                    ram_wdata            = rf_data;
                    if (cnt == LAST) begin
                        rf_done  = 1'b1;
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            wb_pend  <= 1'b0;
            rf_pend  <= 1'b0;
            wb_idx_q <= '0;
            rf_idx_q <= '0;
            cur_idx  <= '0;
            cnt      <= '0;
            ld_pend  <= 1'b0;
            ld_off   <= '0;
            for (int unsigned w = 0; w < WORDS; w++)
                lbuf[w] <= '0;
        end else begin
            state <= state_nx;

            if (wb_start)
                wb_idx_q <= wb_index;
            if (enter_wb) begin
                wb_pend <= 1'b0;
                cur_idx <= wb_start ? wb_index : wb_idx_q;
            end else if (wb_start)
                wb_pend <= 1'b1;

            if (rf_start)
                rf_idx_q <= rf_index;
            if (enter_rf) begin
                rf_pend <= 1'b0;
                cur_idx <= rf_start ? rf_index : rf_idx_q;
            end else if (rf_start)
                rf_pend <= 1'b1;

            if (state == WB_CAP || enter_rf)
                cnt <= '0;
            else if ((state == WB_SEND && wb_ready) || (state == RF_FILL && rf_valid))
                cnt <= cnt + 1'b1;

            if (state == WB_CAP)
                for (int unsigned w = 0; w < WORDS; w++)
                    lbuf[w] <= ram_rdata[32*w +: 32];

            ld_pend <= cpu_acc && (cpu_wen == '0);
            if (cpu_acc)
                ld_off <= cpu_off;
        end
    end

endmodule
